bubble_sort_ctrl: RTL and testbench

//  Control FSM for the 4-entry bubble-sort datapath. Sequences clear, user load, compare and swap.

---
 rtl/bsort_pkg.sv | 22 ++
 rtl/bubble_sort_ctrl_if.sv | 40 ++++
 rtl/bsort_idx_counter.sv | 72 +++++++
 rtl/bubble_sort_ctrl.sv | 164 ++++++++++++++++
 tb/tb_bubble_sort_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/bsort_pkg.sv
// Shared types and constants for the bubble-sort controller slice.
//   state_t  : controller FSM states
//   BSORT_N  : default number of sort entries
//   BSORT_IDX_W : index width derived from BSORT_N
package bsort_pkg;

    localparam int unsigned BSORT_N     = 4;
    localparam int unsigned BSORT_IDX_W = $clog2(BSORT_N);

    typedef enum logic [3:0] {
        CLEAR,
        LOAD,
        LOADED,
        LD_A,
        LD_B,
        CMP,
        SWAP_I,
        SWAP_J,
        DONE
    } state_t;

endpackage : bsort_pkg

// File: rtl/bubble_sort_ctrl_if.sv
// Control bus between the bubble-sort controller and its datapath.
//   write/start : user strobes (into controller)
//   a_gt_b      : comparator flag from datapath
//   reg_en .. done : controller outputs driving the datapath
// Modport master = controller side, slave = datapath/user side.
interface bubble_sort_ctrl_if
    import bsort_pkg::*;
#(
    parameter int unsigned N     = BSORT_N,
    parameter int unsigned IDX_W = $clog2(N)
) ();

    logic             write;
    logic             start;
    logic             a_gt_b;
    logic [N-1:0]     reg_en;
    logic             a_en;
    logic             b_en;
    logic             c_sel;
    logic [IDX_W-1:0] idx_i;
    logic [IDX_W-1:0] idx_j;
    logic             ab_sel;
    logic             reg_init;
    logic             init;
    logic             busy;
    logic             done;

    modport master (
        input  write, start, a_gt_b,
        output reg_en, a_en, b_en, c_sel, idx_i, idx_j,
               ab_sel, reg_init, init, busy, done
    );

    modport slave (
        output write, start, a_gt_b,
        input  reg_en, a_en, b_en, c_sel, idx_i, idx_j,
               ab_sel, reg_init, init, busy, done
    );

endinterface : bubble_sort_ctrl_if

// File: rtl/bsort_idx_counter.sv
// Compare-index, pass and swap-flag bookkeeping for the bubble sort.
//   clk, rst_n       : clock, synchronous active-low reset
//   clear_i          : restart at i=0, pass=0, swapped=0
//   step_i           : advance to next compare (wraps into next pass at end of pass)
//   set_swap_i       : record that the current pass swapped
//   idx_o            : current compare index i
//   last_in_pass_o   : i is the last compare of the current pass
//   sort_finished_o  : ending the current pass ends the sort
module bsort_idx_counter
    import bsort_pkg::*;
#(
    parameter int unsigned N     = BSORT_N,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             step_i,
    input  logic             set_swap_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_in_pass_o,
    output logic             sort_finished_o
);

    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] pass_q, pass_d;
    logic             swapped_q, swapped_d;

    // pass never exceeds N-2, so the subtraction cannot underflow
    assign last_in_pass_o  = (i_q == (IDX_W'(N - 2) - pass_q));
    // Qualified by last_in_pass_o in the controller
    assign sort_finished_o = !swapped_q || (pass_q == IDX_W'(N - 2));
    assign idx_o           = i_q;

    // Next-state for i / pass / swapped
    always_comb begin
        i_d       = i_q;
        pass_d    = pass_q;
        swapped_d = swapped_q;
        if (clear_i) begin
            i_d       = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
        end else begin
            if (set_swap_i) begin
                swapped_d = 1'b1;
            end
            if (step_i) begin
                if (last_in_pass_o) begin
                    pass_d    = pass_q + IDX_W'(1);
                    i_d       = '0;
                    swapped_d = 1'b0;
                end else begin
                    i_d = i_q + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_q       <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
        end else begin
            i_q       <= i_d;
            pass_q    <= pass_d;
            swapped_q <= swapped_d;
        end
    end

endmodule : bsort_idx_counter

// File: rtl/bubble_sort_ctrl.sv
// Control FSM for the N-entry bubble-sort datapath: clear, user load,
// compare and swap, ascending with early exit on a swap-free pass.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : bubble_sort_ctrl_if.master (strobes/flag in, datapath controls out)
// Datapath controls are decoded from the state register; in LOAD/LOADED the
// register enable follows the write strobe in the same cycle so writedata is
// captured on that edge.
module bubble_sort_ctrl
    import bsort_pkg::*;
#(
    parameter int unsigned N     = BSORT_N,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bubble_sort_ctrl_if.master   bus
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;

    logic             cnt_clear, cnt_step, cnt_set_swap;
    logic [IDX_W-1:0] idx;
    logic             last_in_pass, sort_finished;

    logic [N-1:0]     reg_en;
    logic             a_en, b_en, c_sel, ab_sel, reg_init, init, busy, done;

    bsort_idx_counter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear_i         (cnt_clear),
        .step_i          (cnt_step),
        .set_swap_i      (cnt_set_swap),
        .idx_o           (idx),
        .last_in_pass_o  (last_in_pass),
        .sort_finished_o (sort_finished)
    );

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_clear    = 1'b0;
        cnt_step     = 1'b0;
        cnt_set_swap = 1'b0;
        reg_en       = '0;
        a_en         = 1'b0;
        b_en         = 1'b0;
        c_sel        = 1'b0;
        ab_sel       = 1'b0;
        reg_init     = 1'b0;
        init         = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            CLEAR: begin
                reg_en   = '1;
                reg_init = 1'b1;
                init     = 1'b1;
                wr_ptr_d = '0;
                state_d  = LOAD;
            end
            LOAD: begin
                if (bus.write) begin
                    reg_en   = N'(1) << wr_ptr_q;
                    reg_init = 1'b1;
                    wr_ptr_d = wr_ptr_q + IDX_W'(1);
                    if (wr_ptr_q == IDX_W'(N - 1)) begin
                        state_d = LOADED;
                    end
                end
            end
            LOADED: begin
                // start has priority; a lone write restarts the load at slot 0
                if (bus.start) begin
                    cnt_clear = 1'b1;
                    state_d   = LD_A;
                end else if (bus.write) begin
                    reg_en   = N'(1);
                    reg_init = 1'b1;
                    wr_ptr_d = IDX_W'(1);
                    state_d  = LOAD;
                end
            end
            LD_A: begin
                busy    = 1'b1;
                a_en    = 1'b1;
                state_d = LD_B;
            end
            LD_B: begin
                busy    = 1'b1;
                c_sel   = 1'b1;
                b_en    = 1'b1;
                state_d = CMP;
            end
            CMP: begin
                busy = 1'b1;
                if (bus.a_gt_b) begin
                    cnt_set_swap = 1'b1;
                    state_d      = SWAP_I;
                end else if (last_in_pass && sort_finished) begin
                    state_d = DONE;
                end else begin
                    cnt_step = 1'b1;
                    state_d  = LD_A;
                end
            end
            SWAP_I: begin
                busy    = 1'b1;
                ab_sel  = 1'b1;
                reg_en  = N'(1) << idx;
                state_d = SWAP_J;
            end
            SWAP_J: begin
                busy   = 1'b1;
                c_sel  = 1'b1;
                reg_en = N'(1) << (idx + IDX_W'(1));
                if (last_in_pass && sort_finished) begin
                    state_d = DONE;
                end else begin
                    cnt_step = 1'b1;
                    state_d  = LD_A;
                end
            end
            DONE: begin
                done     = 1'b1;
                wr_ptr_d = '0;
                state_d  = LOAD;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= CLEAR;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    assign bus.reg_en   = reg_en;
    assign bus.a_en     = a_en;
    assign bus.b_en     = b_en;
    assign bus.c_sel    = c_sel;
    assign bus.ab_sel   = ab_sel;
    assign bus.reg_init = reg_init;
    assign bus.init     = init;
    assign bus.busy     = busy;
    assign bus.done     = done;
    // Outside the sort the index mirrors the write pointer so mux readback stays defined
    assign bus.idx_i    = busy ? idx : wr_ptr_q;
    assign bus.idx_j    = busy ? (idx + IDX_W'(1)) : '0;

endmodule : bubble_sort_ctrl

// File: tb/tb_bubble_sort_ctrl.sv
// Bench for bubble_sort_ctrl: models the 4-register datapath (regs, A, B,
// comparator) and checks sorted results and sort latency against a plain
// bubble-sort reference.
module tb_bubble_sort_ctrl;
    import bsort_pkg::*;

    typedef logic [3:0][7:0] vals_t;

    typedef struct {
        vals_t d;
        vals_t sorted;
        int    cycles;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wdata;
    logic [7:0] dreg [4];
    logic [7:0] a_q, b_q;
    int         n_vec = 0;
    int         n_err = 0;

    bubble_sort_ctrl_if bus ();

    bubble_sort_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Datapath model
    assign bus.a_gt_b = a_q > b_q;
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (bus.reg_en[k])
                dreg[k] <= bus.reg_init ? (bus.init ? 8'd0 : wdata)
                                        : (bus.ab_sel ? b_q : a_q);
        end
        if (bus.a_en) a_q <= dreg[bus.c_sel ? bus.idx_j : bus.idx_i];
        if (bus.b_en) b_q <= dreg[bus.c_sel ? bus.idx_j : bus.idx_i];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: textbook bubble sort with early exit; 3 cycles per compare, +2 per swap
    function automatic void ref_sort(input vals_t d, output vals_t s, output int cyc);
        logic [7:0] t;
        bit         sw;
        s   = d;
        cyc = 0;
        for (int p = 0; p <= 2; p++) begin
            sw = 1'b0;
            for (int i = 0; i <= 2 - p; i++) begin
                cyc += 3;
                if (s[i] > s[i+1]) begin
                    t = s[i]; s[i] = s[i+1]; s[i+1] = t;
                    cyc += 2;
                    sw = 1'b1;
                end
            end
            if (!sw) break;
        end
    endfunction

    task automatic check_clear(input string name);
        chk({name, "_reg_en"}, int'(bus.reg_en), 15);
        chk({name, "_init"}, int'({bus.init, bus.reg_init}), 3);
        chk({name, "_others"}, int'({bus.a_en, bus.b_en, bus.c_sel, bus.ab_sel,
                                     bus.busy, bus.done, bus.idx_i, bus.idx_j}), 0);
    endtask

    task automatic load_vals(input vals_t d);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.write = 1'b1;
            wdata     = d[k];
        end
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    // Called at the negedge right after load_vals (state LOADED)
    task automatic sort_and_check(input string name, input vals_t exp_s, input int exp_cyc,
                                  input bit noise, input bit wr_with_start);
        int cyc = 0;
        bus.start = 1'b1;
        if (wr_with_start) begin
            bus.write = 1'b1;
            wdata     = 8'hEE;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.write = 1'b0;
        for (int t = 0; t < 64; t++) begin
            if (!bus.busy) break;
            cyc++;
            if (noise) begin
                bus.write = 1'($urandom_range(0, 1));
                bus.start = 1'($urandom_range(0, 1));
                wdata     = 8'($urandom);
            end
            @(negedge clk);
        end
        bus.write = 1'b0;
        bus.start = 1'b0;
        chk({name, "_cycles"}, cyc, exp_cyc);
        chk({name, "_done"}, int'(bus.done), 1);
        for (int k = 0; k < 4; k++) chk({name, "_reg"}, int'(dreg[k]), int'(exp_s[k]));
        @(negedge clk);
        chk({name, "_done_pulse"}, int'(bus.done), 0);
    endtask

    initial begin
        vec_t  vt [5];
        vals_t s, d;
        int    c;
        bit    found;

        vt[0] = '{d: {8'd2, 8'd4, 8'd1, 8'd3}, sorted: {8'd4, 8'd3, 8'd2, 8'd1}, cycles: 24};
        vt[1] = '{d: {8'd4, 8'd3, 8'd2, 8'd1}, sorted: {8'd4, 8'd3, 8'd2, 8'd1}, cycles: 9};
        vt[2] = '{d: {8'd1, 8'd2, 8'd3, 8'd4}, sorted: {8'd4, 8'd3, 8'd2, 8'd1}, cycles: 30};
        vt[3] = '{d: {8'd1, 8'd1, 8'd2, 8'd2}, sorted: {8'd2, 8'd2, 8'd1, 8'd1}, cycles: 26};
        vt[4] = '{d: {8'd5, 8'd5, 8'd0, 8'd9}, sorted: {8'd9, 8'd5, 8'd5, 8'd0}, cycles: 21};

        rst_n     = 1'b0;
        bus.write = 1'b0;
        bus.start = 1'b0;
        wdata     = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_clear("clear");
        @(negedge clk);
        for (int k = 0; k < 4; k++) chk("clear_reg", int'(dreg[k]), 0);
        chk("load_idle_en", int'(bus.reg_en), 0);

        // Directed table
        for (int v = 0; v < 5; v++) begin
            load_vals(vt[v].d);
            sort_and_check($sformatf("vec%0d", v), vt[v].sorted, vt[v].cycles, 1'b0, 1'b0);
        end

        // start in LOAD ignored, then finish the load and sort
        @(negedge clk);
        bus.write = 1'b1; wdata = 8'd5;
        @(negedge clk);
        bus.write = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_in_load_busy", int'(bus.busy), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.write = 1'b1;
            wdata     = 8'(8 - 3 * k);
        end
        @(negedge clk);
        bus.write = 1'b0;
        ref_sort({8'd2, 8'd5, 8'd8, 8'd5}, s, c);
        sort_and_check("start_in_load", s, c, 1'b0, 1'b0);

        // Write in LOADED restarts the load at slot 0
        load_vals({8'd1, 8'd1, 8'd1, 8'd1});
        load_vals({8'd3, 8'd6, 8'd0, 8'd7});
        ref_sort({8'd3, 8'd6, 8'd0, 8'd7}, s, c);
        sort_and_check("reload", s, c, 1'b0, 1'b0);

        // Write together with start is dropped; noise during busy is ignored
        load_vals({8'd10, 8'd20, 8'd30, 8'd40});
        ref_sort({8'd10, 8'd20, 8'd30, 8'd40}, s, c);
        sort_and_check("wr_with_start", s, c, 1'b1, 1'b1);

        // Reset during SWAP_I aborts and clears, then a fresh sort works
        load_vals(vt[2].d);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (bus.busy && bus.ab_sel) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("swap_i_reached", int'(found), 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_clear("mid_rst");
        @(negedge clk);
        for (int k = 0; k < 4; k++) chk("mid_rst_reg", int'(dreg[k]), 0);
        load_vals(vt[4].d);
        sort_and_check("after_rst", vt[4].sorted, vt[4].cycles, 1'b0, 1'b0);

        // Randomized against the reference, small values for duplicates
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < 4; k++) d[k] = 8'($urandom_range(0, 15));
            ref_sort(d, s, c);
            load_vals(d);
            sort_and_check($sformatf("rand%0d", r), s, c, 1'(r % 2), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bubble_sort_ctrl
